// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder_ctrl
// Purpose  : Bit-serial N-bit adder. One full-adder bit per clock, LSB first,
//            with valid/ready handshakes on the operands and the result.
// Revision : 1.0 - initial release
// ============================================================================
module serial_adder_ctrl #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin0,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] S,
    output logic         Cout,
    output logic         busy
);
    localparam int                 c_CNT_W    = (N > 1) ? $clog2(N) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(N - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [N-1:0]       a_sr_q, a_sr_d;
    logic [N-1:0]       b_sr_q, b_sr_d;
    logic [N-1:0]       s_sr_q, s_sr_d;
    logic [N-1:0]       s_q, s_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic [c_CNT_W-1:0] cnt_q, cnt_d;

    logic               w_fa_s;
    logic               w_fa_co;
    logic [N-1:0]       w_s_shift;

    always_comb begin
        w_fa_s  = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
        w_fa_co = (a_sr_q[0] & b_sr_q[0]) | (carry_q & (a_sr_q[0] ^ b_sr_q[0]));
    end

    // Each new sum bit enters at the MSB, so after N shifts bit 0 holds the LSB.
    always_comb begin
        w_s_shift        = s_sr_q >> 1;
        w_s_shift[N-1]   = w_fa_s;
    end

    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        s_sr_d  = s_sr_q;
        s_d     = s_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_sr_d  = A;
                    b_sr_d  = B;
                    carry_d = Cin0;
                    cnt_d   = '0;
                    state_d = ST_ADD;
                end
            end
            ST_ADD: begin
                carry_d = w_fa_co;
                s_sr_d  = w_s_shift;
                a_sr_d  = a_sr_q >> 1;
                b_sr_d  = b_sr_q >> 1;
                cnt_d   = cnt_q + c_CNT_ONE;
                if (cnt_q == c_CNT_LAST) begin
                    s_d     = w_s_shift;
                    cout_d  = w_fa_co;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            s_sr_q  <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            s_sr_q  <= s_sr_d;
            s_q     <= s_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

    // Handshake flags depend on state alone, never on in_valid/out_ready.
    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_ADD);
    assign out_valid = (state_q == ST_DONE);
    assign S         = s_q;
    assign Cout      = cout_q;

endmodule
`default_nettype wire
